// File: rtl/iob_eth_rx_mii.sv
// iob_eth_rx_mii - MII receive front-end.
//
// Samples RX_DV/RX_ER/RX_DATA on RX_CLK, strips the preamble and SFD, and
// reassembles nibbles (low nibble first) into bytes. Delivers a byte stream
// with start/end-of-frame markers, the frame byte length and an error flag.
//
// Ports:
//   RX_CLK        PHY receive clock
//   rst           asynchronous active-high reset (released through a 2-flop sync)
//   RX_DV         MII receive data valid
//   RX_ER         MII receive error
//   RX_DATA[3:0]  MII receive nibble
//   byte_o[7:0]   received byte
//   byte_valid_o  one-cycle strobe, byte_o valid
//   sof_o         first byte after SFD (coincident with byte_valid_o)
//   eof_o         one-cycle end-of-frame strobe
//   err_o         frame error, valid at eof_o, held until next sof_o
//   len_o[10:0]   frame byte count, valid at eof_o, held until next sof_o
//
// Build option: define IOB_ETH_RX_ER_EN to make RX_ER abort the preamble and
// flag an error during frame data. Otherwise RX_ER is ignored.

module iob_eth_rx_mii #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int PRE_MIN   = 2
) (
    input  logic        RX_CLK,
    input  logic        rst,
    input  logic        RX_DV,
    input  logic        RX_ER,
    input  logic [3:0]  RX_DATA,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    output logic        sof_o,
    output logic        eof_o,
    output logic        err_o,
    output logic [10:0] len_o
);

`ifdef IOB_ETH_RX_ER_EN
    localparam logic ER_EN = 1'b1;
`else
    localparam logic ER_EN = 1'b0;
`endif

    localparam logic [10:0] MIN_L     = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_L     = 11'(MAX_FRAME);
    localparam logic [4:0]  PRE_MIN_L = 5'(PRE_MIN);

    typedef enum logic [2:0] {
        S_WAIT, S_IDLE, S_PRE, S_DATA, S_DROP_EOF, S_DROP
    } state_t;

    // Reset asserts asynchronously, releases on RX_CLK after two flops.
    logic [1:0] rst_pipe;
    logic       rst_i;

    always_ff @(posedge RX_CLK or posedge rst) begin
        if (rst) rst_pipe <= 2'b11;
        else     rst_pipe <= {rst_pipe[0], 1'b0};
    end
    assign rst_i = rst_pipe[1];

    // Gated so the port stays read even when the feature is compiled out.
    logic rx_er;
    assign rx_er = RX_ER & ER_EN;

    state_t      state, state_nxt;
    logic [3:0]  pre_cnt, pre_cnt_nxt;
    logic        phase, phase_nxt;
    logic [3:0]  low_nib, low_nib_nxt;
    logic [10:0] cnt, cnt_nxt;
    logic        err_acc, err_acc_nxt;
    logic [7:0]  byte_nxt;
    logic        bv_nxt, sof_nxt, eof_nxt, err_nxt;
    logic [10:0] len_nxt;

    // IDLE evaluates its first nibble as PRE would, starting from zero.
    logic [3:0] pre_eff;
    logic       sfd_ok;
    assign pre_eff = (state == S_IDLE) ? 4'd0 : pre_cnt;
    assign sfd_ok  = ({1'b0, pre_eff} >= PRE_MIN_L);

    // State register
    always_ff @(posedge RX_CLK or posedge rst_i) begin
        if (rst_i) state <= S_WAIT;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT: if (!RX_DV) state_nxt = S_IDLE;
            S_IDLE, S_PRE: begin
                if (!RX_DV)                           state_nxt = S_IDLE;
                else if (rx_er)                       state_nxt = S_DROP;
                else if (RX_DATA == 4'h5)             state_nxt = S_PRE;
                else if (RX_DATA == 4'hD && sfd_ok)   state_nxt = S_DATA;
                else                                  state_nxt = S_DROP;
            end
            S_DATA: begin
                if (!RX_DV)                   state_nxt = S_IDLE;
                else if (phase && cnt == MAX_L) state_nxt = S_DROP_EOF;
            end
            S_DROP_EOF, S_DROP: if (!RX_DV) state_nxt = S_IDLE;
            default: state_nxt = S_WAIT;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        pre_cnt_nxt = pre_cnt;
        phase_nxt   = phase;
        low_nib_nxt = low_nib;
        cnt_nxt     = cnt;
        err_acc_nxt = err_acc;
        byte_nxt    = byte_o;
        bv_nxt      = 1'b0;
        sof_nxt     = 1'b0;
        eof_nxt     = 1'b0;
        err_nxt     = err_o;
        len_nxt     = len_o;
        case (state)
            S_IDLE, S_PRE: begin
                if (RX_DV) begin
                    // Frame counters are primed here so DATA starts clean;
                    // they are don't-care on every other exit from PRE.
                    pre_cnt_nxt = (pre_eff == 4'hF) ? 4'hF : pre_eff + 4'd1;
                    phase_nxt   = 1'b0;
                    cnt_nxt     = '0;
                    err_acc_nxt = 1'b0;
                end
            end
            S_DATA: begin
                if (!RX_DV) begin
                    eof_nxt = 1'b1;
                    err_nxt = err_acc | phase | (cnt < MIN_L);
                    len_nxt = cnt;
                end else begin
                    if (rx_er) err_acc_nxt = 1'b1;
                    if (!phase) begin
                        low_nib_nxt = RX_DATA;
                        phase_nxt   = 1'b1;
                    end else if (cnt == MAX_L) begin
                        err_acc_nxt = 1'b1;
                    end else begin
                        byte_nxt  = {RX_DATA, low_nib};
                        bv_nxt    = 1'b1;
                        sof_nxt   = (cnt == '0);
                        cnt_nxt   = cnt + 11'd1;
                        phase_nxt = 1'b0;
                        if (cnt == '0) begin
                            err_nxt = 1'b0;
                            len_nxt = '0;
                        end
                    end
                end
            end
            S_DROP_EOF: begin
                if (!RX_DV) begin
                    eof_nxt = 1'b1;
                    err_nxt = 1'b1;
                    len_nxt = MAX_L;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge RX_CLK or posedge rst_i) begin
        if (rst_i) begin
            pre_cnt      <= '0;
            phase        <= 1'b0;
            low_nib      <= '0;
            cnt          <= '0;
            err_acc      <= 1'b0;
            byte_o       <= '0;
            byte_valid_o <= 1'b0;
            sof_o        <= 1'b0;
            eof_o        <= 1'b0;
            err_o        <= 1'b0;
            len_o        <= '0;
        end else begin
            pre_cnt      <= pre_cnt_nxt;
            phase        <= phase_nxt;
            low_nib      <= low_nib_nxt;
            cnt          <= cnt_nxt;
            err_acc      <= err_acc_nxt;
            byte_o       <= byte_nxt;
            byte_valid_o <= bv_nxt;
            sof_o        <= sof_nxt;
            eof_o        <= eof_nxt;
            err_o        <= err_nxt;
            len_o        <= len_nxt;
        end
    end

endmodule

// File: tb/tb_iob_eth_rx_mii.sv
// Self-checking bench for iob_eth_rx_mii: expected bytes and end-of-frame
// status are queued as stimulus is driven and popped as the DUT emits them.

module tb_iob_eth_rx_mii;

    localparam int MIN_FRAME = 64;
    localparam int MAX_FRAME = 1518;
    localparam int PRE_MIN   = 2;

`ifdef IOB_ETH_RX_ER_EN
    localparam bit ER_EN = 1'b1;
`else
    localparam bit ER_EN = 1'b0;
`endif

    logic        RX_CLK = 1'b0;
    logic        rst = 1'b0;
    logic        RX_DV = 1'b0;
    logic        RX_ER = 1'b0;
    logic [3:0]  RX_DATA = 4'h0;
    logic [7:0]  byte_o;
    logic        byte_valid_o, sof_o, eof_o, err_o;
    logic [10:0] len_o;

    iob_eth_rx_mii #(
        .MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME), .PRE_MIN(PRE_MIN)
    ) dut (
        .RX_CLK(RX_CLK), .rst(rst), .RX_DV(RX_DV), .RX_ER(RX_ER),
        .RX_DATA(RX_DATA), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
        .sof_o(sof_o), .eof_o(eof_o), .err_o(err_o), .len_o(len_o)
    );

    always #5 RX_CLK = ~RX_CLK;

    typedef struct packed {
        logic        err;
        logic [10:0] len;
    } eof_t;

    logic [8:0] exp_b[$];   // {sof, byte}
    eof_t       exp_e[$];
    int vectors = 0;
    int miscompares = 0;

    logic [8:0] m_b;
    eof_t       m_e;

    // Scoreboard: outputs change on posedge, sampled here on negedge.
    always @(negedge RX_CLK) begin
        if (byte_valid_o) begin
            vectors++;
            if (exp_b.size() == 0) begin
                miscompares++;
                $display("FAIL byte: unexpected byte %h sof %b, none required", byte_o, sof_o);
            end else begin
                m_b = exp_b.pop_front();
                if ({sof_o, byte_o} !== m_b) begin
                    miscompares++;
                    $display("FAIL byte: got sof %b byte %h, required sof %b byte %h",
                             sof_o, byte_o, m_b[8], m_b[7:0]);
                end
            end
        end
        if (eof_o) begin
            vectors++;
            if (exp_e.size() == 0) begin
                miscompares++;
                $display("FAIL eof: unexpected eof err %b len %0d", err_o, len_o);
            end else begin
                m_e = exp_e.pop_front();
                if ({byte_valid_o, err_o, len_o} !== {1'b0, m_e.err, m_e.len}) begin
                    miscompares++;
                    $display("FAIL eof: got bv %b err %b len %0d, required bv 0 err %b len %0d",
                             byte_valid_o, err_o, len_o, m_e.err, m_e.len);
                end
            end
        end
    end

    task automatic send_nib(input logic [3:0] d, input logic er);
        @(negedge RX_CLK);
        RX_DV = 1'b1;
        RX_ER = er;
        RX_DATA = d;
    endtask

    task automatic send_idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge RX_CLK);
            RX_DV = 1'b0;
            RX_ER = 1'b0;
            RX_DATA = 4'h0;
        end
    endtask

    task automatic send_preamble(input bit bad_pre);
        for (int k = 0; k < 15; k++) send_nib((bad_pre && k == 3) ? 4'h7 : 4'h5, 1'b0);
        send_nib(4'hD, 1'b0);
    endtask

    // n bytes of 0,1,2...; one trailing nibble if extra; RX_ER on byte er_byte.
    task automatic send_frame(input int n, input bit bad_pre, input bit extra,
                              input int er_byte, input bit expect_out);
        eof_t e;
        int   l;
        send_preamble(bad_pre);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = i[7:0];
            send_nib(b[3:0], i == er_byte);
            if (expect_out && i < MAX_FRAME) exp_b.push_back({(i == 0), b});
            send_nib(b[7:4], 1'b0);
        end
        if (extra) send_nib(4'hA, 1'b0);
        if (expect_out) begin
            l = (n > MAX_FRAME) ? MAX_FRAME : n;
            e.len = l[10:0];
            e.err = (n < MIN_FRAME) || (n > MAX_FRAME) || extra ||
                    (ER_EN && er_byte >= 0 && er_byte < n);
            exp_e.push_back(e);
        end
        send_idle(1);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((exp_b.size() != 0 || exp_e.size() != 0) && t < 100) begin
            @(negedge RX_CLK);
            t++;
        end
        repeat (3) @(negedge RX_CLK);
        vectors++;
        if (exp_b.size() != 0 || exp_e.size() != 0) begin
            miscompares++;
            $display("FAIL %s drain: %0d bytes and %0d eofs outstanding, required 0",
                     name, exp_b.size(), exp_e.size());
        end
        exp_b.delete();
        exp_e.delete();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (3) @(negedge RX_CLK);
        vectors++;
        if ({byte_o, byte_valid_o, sof_o, eof_o, err_o, len_o} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset: outputs byte %h bv %b sof %b eof %b err %b len %0d, required all 0",
                     byte_o, byte_valid_o, sof_o, eof_o, err_o, len_o);
        end
        rst = 1'b0;
        send_idle(5);
    endtask

    task automatic test_good_frame();
        send_frame(64, 1'b0, 1'b0, -1, 1'b1);
        wait_drain("good64");
    endtask

    task automatic test_short_frame();
        send_frame(60, 1'b0, 1'b0, -1, 1'b1);
        wait_drain("short60");
    endtask

    task automatic test_long_frame();
        send_frame(1519, 1'b0, 1'b0, -1, 1'b1);
        wait_drain("long1519");
    endtask

    task automatic test_bad_preamble();
        send_frame(100, 1'b1, 1'b0, -1, 1'b0);
        send_frame(64, 1'b0, 1'b0, -1, 1'b1);
        wait_drain("bad_preamble");
    endtask

    task automatic test_odd_nibble();
        send_frame(64, 1'b0, 1'b1, -1, 1'b1);
        wait_drain("odd_nibble");
    endtask

    task automatic test_rx_er();
        send_frame(64, 1'b0, 1'b0, 10, 1'b1);
        wait_drain("rx_er");
    endtask

    task automatic test_back_to_back();
        send_frame(64, 1'b0, 1'b0, -1, 1'b1);
        send_frame(70, 1'b0, 1'b0, -1, 1'b1);
        send_frame(65, 1'b0, 1'b0, -1, 1'b1);
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        send_preamble(1'b0);
        for (int i = 0; i < 20; i++) begin
            b = i[7:0];
            send_nib(b[3:0], 1'b0);
            exp_b.push_back({(i == 0), b});
            send_nib(b[7:4], 1'b0);
        end
        @(negedge RX_CLK);   // last byte strobe still high here
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({byte_o, byte_valid_o, sof_o, eof_o, err_o, len_o} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_mid: outputs byte %h bv %b sof %b eof %b err %b len %0d, required all 0",
                     byte_o, byte_valid_o, sof_o, eof_o, err_o, len_o);
        end
        @(negedge RX_CLK);
        rst = 1'b0;
        for (int i = 20; i < 64; i++) begin
            b = i[7:0];
            send_nib(b[3:0], 1'b0);
            send_nib(b[7:4], 1'b0);
        end
        send_idle(1);
        send_frame(64, 1'b0, 1'b0, -1, 1'b1);
        wait_drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_short_frame();
        test_long_frame();
        test_bad_preamble();
        test_odd_nibble();
        test_rx_er();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
